// File: rtl/mpx_icache_pkg.sv
// Shared definitions for the mpx instruction cache: FSM encoding and address helpers.
package mpx_icache_pkg;

  typedef enum logic [1:0] {
    ICACHE_STATE_FLUSH     = 2'd0,
    ICACHE_STATE_LOOKUP    = 2'd1,
    ICACHE_STATE_MISS_REQ  = 2'd2,
    ICACHE_STATE_MISS_WAIT = 2'd3
  } icache_state_t;

  localparam int ICACHE_NUM_LINES_DEF = 256;

  function automatic logic [31:0] icache_word_addr(input logic [29:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/mpx_icache_ram.sv
// Single-port RAM, synchronous read, write-first; read data valid the cycle after the address.
// No backpressure: one access per cycle.
module mpx_icache_ram #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (wr_i) r_mem[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_rdata <= '0;
    else if (wr_i) r_rdata <= wdata_i;
    else           r_rdata <= r_mem[addr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/mpx_icache.sv
// Direct-mapped 1-word-line icache: hit response 1 cycle after accept, miss = lookup + memory latency.
// req_accept_o is low while flushing, on a detected miss and until the refill returns.
module mpx_icache
  import mpx_icache_pkg::*;
#(
  parameter int NUM_LINES = ICACHE_NUM_LINES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_rd_i,
  input  logic        req_flush_i,
  input  logic        req_invalidate_i,
  input  logic [31:0] req_pc_i,
  input  logic        req_priv_i,
  output logic        req_accept_o,
  output logic        req_valid_o,
  output logic        req_error_o,
  output logic [31:0] req_inst_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic        mem_error_i,
  input  logic [31:0] mem_data_i
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    r_state, w_state_d;
  logic [IDX_W-1:0] r_flush_idx, w_flush_idx_d;
  logic             r_lookup, w_lookup_d;
  logic [31:2]      r_pc, w_pc_d;

  logic [IDX_W-1:0] w_tag_addr, w_data_addr;
  logic             w_tag_wr, w_data_wr;
  logic [TAG_W:0]   w_tag_wdata, w_tag_rdata;
  logic [31:0]      w_data_wdata, w_data_rdata;
  logic             w_refill;

  wire [IDX_W-1:0] w_req_idx = req_pc_i[2+IDX_W-1:2];
  wire [IDX_W-1:0] w_pc_idx  = r_pc[2+IDX_W-1:2];
  wire [TAG_W-1:0] w_pc_tag  = r_pc[31:2+IDX_W];
  wire             w_hit     = r_lookup && w_tag_rdata[TAG_W] && (w_tag_rdata[TAG_W-1:0] == w_pc_tag);
  wire             w_unused  = ^{req_priv_i, req_pc_i[1:0]};

  mpx_icache_ram #(.WIDTH(TAG_W+1), .DEPTH(NUM_LINES)) u_tag_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (w_tag_addr),
    .wr_i    (w_tag_wr),
    .wdata_i (w_tag_wdata),
    .rdata_o (w_tag_rdata)
  );

  mpx_icache_ram #(.WIDTH(32), .DEPTH(NUM_LINES)) u_data_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (w_data_addr),
    .wr_i    (w_data_wr),
    .wdata_i (w_data_wdata),
    .rdata_o (w_data_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ICACHE_STATE_FLUSH;
      r_flush_idx <= '0;
      r_lookup    <= 1'b0;
      r_pc        <= '0;
    end else begin
      r_state     <= w_state_d;
      r_flush_idx <= w_flush_idx_d;
      r_lookup    <= w_lookup_d;
      r_pc        <= w_pc_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_flush_idx_d = r_flush_idx;
    w_lookup_d    = 1'b0;
    w_pc_d        = r_pc;
    w_tag_addr    = w_req_idx;
    w_tag_wr      = 1'b0;
    w_tag_wdata   = '0;
    w_data_addr   = w_req_idx;
    w_data_wr     = 1'b0;
    w_data_wdata  = mem_data_i;
    w_refill      = 1'b0;
    req_accept_o  = 1'b0;
    req_valid_o   = 1'b0;
    req_error_o   = 1'b0;
    req_inst_o    = '0;
    mem_rd_o      = 1'b0;
    mem_addr_o    = '0;

    case (r_state)
      ICACHE_STATE_FLUSH: begin
        w_tag_addr    = r_flush_idx;
        w_tag_wr      = 1'b1;
        w_flush_idx_d = r_flush_idx + 1'b1;
        if (r_flush_idx == IDX_W'(NUM_LINES - 1)) w_state_d = ICACHE_STATE_LOOKUP;
      end
      ICACHE_STATE_LOOKUP: begin
        if (w_hit) begin
          req_valid_o = 1'b1;
          req_inst_o  = w_data_rdata;
        end
        if (r_lookup && !w_hit) begin
          w_state_d = ICACHE_STATE_MISS_REQ;
        end else begin
          req_accept_o = 1'b1;
          if (req_flush_i) begin
            w_state_d     = ICACHE_STATE_FLUSH;
            w_flush_idx_d = '0;
          end else if (req_invalidate_i) begin
            w_tag_wr = 1'b1;
          end else if (req_rd_i) begin
            w_lookup_d = 1'b1;
            w_pc_d     = req_pc_i[31:2];
          end
        end
      end
      ICACHE_STATE_MISS_REQ: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = icache_word_addr(r_pc);
        if (mem_accept_i) begin
          w_state_d = ICACHE_STATE_MISS_WAIT;
          w_refill  = mem_valid_i;
        end
      end
      ICACHE_STATE_MISS_WAIT: w_refill = mem_valid_i;
      default: w_state_d = ICACHE_STATE_FLUSH;
    endcase

    // Refill bypasses straight to the response; faulting words leave the line invalid.
    if (w_refill) begin
      req_valid_o = 1'b1;
      req_inst_o  = mem_data_i;
      req_error_o = mem_error_i;
      w_tag_addr  = w_pc_idx;
      w_data_addr = w_pc_idx;
      w_tag_wr    = 1'b1;
      w_data_wr   = 1'b1;
      w_tag_wdata = {~mem_error_i, w_pc_tag};
      w_state_d   = ICACHE_STATE_LOOKUP;
    end
  end

  a_one_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    !(req_rd_i && (r_state == ICACHE_STATE_MISS_REQ || r_state == ICACHE_STATE_MISS_WAIT)));

endmodule

// File: tb/tb_mpx_icache.sv
// Directed bench for mpx_icache with a line-level cache model and a per-cycle compare process.
module tb_mpx_icache;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_rd_i, req_flush_i, req_invalidate_i, req_priv_i;
  logic [31:0] req_pc_i;
  logic        req_accept_o, req_valid_o, req_error_o;
  logic [31:0] req_inst_o;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic        mem_accept_i, mem_valid_i, mem_error_i;
  logic [31:0] mem_data_i;

  int n_checks = 0;
  int n_err    = 0;

  mpx_icache dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_rd_i(req_rd_i), .req_flush_i(req_flush_i), .req_invalidate_i(req_invalidate_i),
    .req_pc_i(req_pc_i), .req_priv_i(req_priv_i),
    .req_accept_o(req_accept_o), .req_valid_o(req_valid_o), .req_error_o(req_error_o),
    .req_inst_o(req_inst_o),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_accept_i(mem_accept_i),
    .mem_valid_i(mem_valid_i), .mem_error_i(mem_error_i), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h2402_0001;
    if (a == 32'h0000_2000) return 32'h3C1D_0010;
    return {~a[15:0], a[15:0]};
  endfunction

  // ---------------- memory responder ----------------
  int          mem_lat     = 3;
  int          mem_acc_dly = 0;
  logic [31:0] err_addr    = 32'hFFFF_FFFF;
  int          rphase = 0, acnt = 0, vcnt = 0;
  logic [31:0] maddr = '0;

  initial begin
    mem_accept_i = 0; mem_valid_i = 0; mem_error_i = 0; mem_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_accept_i = 0; mem_valid_i = 0; mem_error_i = 0;
      if (rphase == 0 && mem_rd_o) begin rphase = 1; acnt = mem_acc_dly; end
      if (rphase == 1) begin
        if (acnt == 0) begin
          mem_accept_i = 1; maddr = mem_addr_o;
          if (mem_lat == 0) begin
            mem_valid_i = 1; mem_data_i = mem_word(maddr); mem_error_i = (maddr == err_addr);
            rphase = 0;
          end else begin
            vcnt = mem_lat; rphase = 2;
          end
        end else acnt--;
      end else if (rphase == 2) begin
        vcnt--;
        if (vcnt == 0) begin
          mem_valid_i = 1; mem_data_i = mem_word(maddr); mem_error_i = (maddr == err_addr);
          rphase = 0;
        end
      end
    end
  end

  // ---------------- line-level model + compare ----------------
  localparam int P_IDLE = 0, P_RESOLVE = 1, P_MISS = 2;
  logic [31:0] m_addr [int];
  logic [31:0] m_dat  [int];
  int          flush_cnt = 256;
  int          phase = P_IDLE;
  bit          m_acc = 0;
  logic [31:0] pend = '0;

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hFF);
  endfunction

  initial begin
    bit ev, ea, emr, ee;
    logic [31:0] ei;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        m_addr.delete(); m_dat.delete();
        flush_cnt = 256; phase = P_IDLE; m_acc = 0;
        chk("rst_accept", 32'(req_accept_o), 0);
        chk("rst_valid",  32'(req_valid_o), 0);
        chk("rst_error",  32'(req_error_o), 0);
        chk("rst_inst",   req_inst_o, 0);
        chk("rst_mem_rd", 32'(mem_rd_o), 0);
        chk("rst_mem_addr", mem_addr_o, 0);
      end else begin
        ev = 0; ea = 0; emr = 0; ee = 0; ei = '0;
        if (flush_cnt > 0) flush_cnt--;
        else begin
          case (phase)
            P_IDLE: ea = 1;
            P_RESOLVE: begin
              if (m_addr.exists(line_of(pend)) && m_addr[line_of(pend)] == (pend & ~32'h3)) begin
                ev = 1; ei = m_dat[line_of(pend)]; ea = 1; phase = P_IDLE;
              end else begin
                phase = P_MISS; m_acc = 0;
              end
            end
            default: begin
              emr = !m_acc;
              if (!m_acc && mem_accept_i) m_acc = 1;
              if (m_acc && mem_valid_i) begin
                ev = 1; ei = mem_data_i; ee = mem_error_i;
                if (!mem_error_i) begin
                  m_addr[line_of(pend)] = pend & ~32'h3;
                  m_dat[line_of(pend)]  = mem_data_i;
                end else if (m_addr.exists(line_of(pend))) begin
                  m_addr.delete(line_of(pend));
                end
                phase = P_IDLE;
              end
            end
          endcase
        end
        chk("accept", 32'(req_accept_o), 32'(ea));
        chk("valid",  32'(req_valid_o), 32'(ev));
        if (ev) begin
          chk("inst",  req_inst_o, ei);
          chk("error", 32'(req_error_o), 32'(ee));
        end
        chk("mem_rd", 32'(mem_rd_o), 32'(emr));
        if (emr) chk("mem_addr", mem_addr_o, pend & ~32'h3);
        if (ea) begin
          if (req_flush_i) begin
            m_addr.delete(); m_dat.delete(); flush_cnt = 256; phase = P_IDLE;
          end else if (req_invalidate_i) begin
            if (m_addr.exists(line_of(req_pc_i))) m_addr.delete(line_of(req_pc_i));
          end else if (req_rd_i) begin
            pend = req_pc_i; phase = P_RESOLVE;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Tasks begin and end one time unit after a rising edge.
  task automatic issue(input bit fl, input bit inv, input bit rd, input logic [31:0] pc, output int waited);
    req_flush_i = fl; req_invalidate_i = inv; req_rd_i = rd; req_pc_i = pc;
    waited = 0;
    while (1) begin
      @(negedge clk_i); waited++;
      if (req_accept_o) break;
      if (waited >= 400) begin chk("accept_timeout", 32'(waited), 0); break; end
    end
    @(posedge clk_i); #1;
    req_flush_i = 0; req_invalidate_i = 0; req_rd_i = 0;
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] inst, output bit err);
    lat = 0; inst = '0; err = 0;
    while (1) begin
      @(negedge clk_i); lat++;
      if (req_valid_o) begin inst = req_inst_o; err = req_error_o; break; end
      if (lat >= 50) begin chk("resp_timeout", 32'(lat), 0); break; end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic rd_check(input string nm, input logic [31:0] pc, input int exp_lat,
                          input logic [31:0] exp_inst, input bit exp_err);
    int w, lat; logic [31:0] inst; bit err;
    issue(0, 0, 1, pc, w);
    wait_resp(lat, inst, err);
    chk({nm, "_lat"},  32'(lat), 32'(exp_lat));
    chk({nm, "_inst"}, inst, exp_inst);
    chk({nm, "_err"},  32'(err), 32'(exp_err));
  endtask

  task automatic wait_flush_done(input string nm);
    int n = 0;
    while (1) begin
      @(negedge clk_i); n++;
      if (req_accept_o || n >= 400) break;
    end
    chk(nm, 32'(n), 32'd257);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int w;
    rst_i = 1; req_rd_i = 0; req_flush_i = 0; req_invalidate_i = 0; req_priv_i = 0; req_pc_i = '0;
    repeat (3) @(posedge clk_i); #1;
    rst_i = 0;
    wait_flush_done("reset_flush_len");

    rd_check("cold_miss",   32'h0000_1000, 5, 32'h2402_0001, 0);
    rd_check("hit",         32'h0000_1000, 1, 32'h2402_0001, 0);
    req_priv_i = 1;
    rd_check("hit_lowbits", 32'h0000_1002, 1, 32'h2402_0001, 0);
    req_priv_i = 0;
    rd_check("alias",       32'h0000_2000, 5, 32'h3C1D_0010, 0);
    rd_check("alias_back",  32'h0000_1000, 5, 32'h2402_0001, 0);

    err_addr = 32'h0000_4000;
    rd_check("err_miss",    32'h0000_4000, 5, 32'hBFFF_4000, 1);
    rd_check("err_again",   32'h0000_4000, 5, 32'hBFFF_4000, 1);
    err_addr = 32'hFFFF_FFFF;

    mem_lat = 0;
    rd_check("same_cycle",     32'h0000_5000, 2, 32'hAFFF_5000, 0);
    mem_lat = 3;
    rd_check("same_cycle_hit", 32'h0000_5000, 1, 32'hAFFF_5000, 0);

    mem_acc_dly = 2;
    rd_check("acc_hold",    32'h0000_6000, 7, 32'h9FFF_6000, 0);
    mem_acc_dly = 0;

    // Flush held across a refill is only taken once the refill is done.
    rd_check("pre_flush",   32'h0000_3000, 5, 32'hCFFF_3000, 0);
    rd_check("pre_flush_hit", 32'h0000_3000, 1, 32'hCFFF_3000, 0);
    issue(0, 0, 1, 32'h0000_1000, w);
    issue(1, 0, 0, 32'h0, w);
    chk("flush_wait", 32'(w), 32'd6);
    issue(0, 0, 1, 32'h0000_3000, w);
    chk("post_flush_accept", 32'(w), 32'd257);
    begin
      int lat; logic [31:0] inst; bit err;
      wait_resp(lat, inst, err);
      chk("post_flush_miss_lat", 32'(lat), 32'd5);
      chk("post_flush_inst", inst, 32'hCFFF_3000);
    end

    rd_check("fill0", 32'h0000_1000, 5, 32'h2402_0001, 0);
    rd_check("fill1", 32'h0000_1004, 5, 32'hEFFB_1004, 0);
    rd_check("fill2", 32'h0000_1008, 5, 32'hEFF7_1008, 0);
    rd_check("fill3", 32'h0000_100C, 5, 32'hEFF3_100C, 0);
    issue(0, 1, 0, 32'h0000_1000, w);
    chk("inval_accept", 32'(w), 32'd1);
    rd_check("inval_other_hit", 32'h0000_1004, 1, 32'hEFFB_1004, 0);
    rd_check("inval_miss",      32'h0000_1000, 5, 32'h2402_0001, 0);

    for (int i = 0; i < 4; i++) begin
      req_rd_i = 1; req_pc_i = 32'h0000_1000 + 32'(4 * i);
      @(negedge clk_i);
      chk("b2b_accept", 32'(req_accept_o), 1);
      if (i > 0) begin
        chk("b2b_valid", 32'(req_valid_o), 1);
        chk("b2b_inst", req_inst_o, mem_word(32'h0000_1000 + 32'(4 * (i - 1))));
      end
      @(posedge clk_i); #1;
    end
    req_rd_i = 0;
    @(negedge clk_i);
    chk("b2b_valid_last", 32'(req_valid_o), 1);
    chk("b2b_inst_last", req_inst_o, 32'hEFF3_100C);
    @(posedge clk_i); #1;

    // Reset while the refill request is outstanding; the late memory reply lands during FLUSH.
    mem_acc_dly = 5;
    issue(0, 0, 1, 32'h0000_7000, w);
    w = 0;
    while (!mem_rd_o && w < 20) begin @(negedge clk_i); w++; end
    chk("miss_req_seen", 32'(mem_rd_o), 1);
    #1 rst_i = 1;
    #1 chk("rst_mem_rd_drop", 32'(mem_rd_o), 0);
    repeat (2) @(posedge clk_i); #1;
    rst_i = 0;
    wait_flush_done("rst_mid_refill_flush_len");
    mem_acc_dly = 0;
    rd_check("post_rst_miss", 32'h0000_7000, 5, 32'h8FFF_7000, 0);

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #300000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
